// File: rtl/uart_tx_module.sv
// uart_tx_module -- UART transmitter with an integrated bit-period timer.
// Sends one byte per accepted request as an 8N1 frame, LSB first, on a
// registered, glitch-free tx line. One bit lasts CLKS_PER_BIT clocks.
// The bit timer counts 0..CLKS_PER_BIT-1, which is the same divisor
// convention the receive path's sampling timer uses.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, an
// even-parity bit is inserted after data bit 7 (8E1, 11-bit frame).
// When it is undefined, the frame is 8N1 and no parity logic is built.
module uart_tx_module #(
  parameter int CLKS_PER_BIT = 2083
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  // Last count of a bit period. Legal CLKS_PER_BIT is 2..65535.
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q,   idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q,    tx_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic        bit_end;
`ifdef UART_TX_PARITY_EN
  logic        par_q,   par_d;
`endif

  assign bit_end = (timer_q == LAST_CNT);

  // Control state: reset returns the line to idle-high and abandons any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= 16'd0;
      idx_q   <= 3'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Frame data: reloaded on every accepted request, so no reset is needed.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  // Next-state logic: the timer runs only while a frame is in progress, and
  // tx is updated only at bit boundaries so the line never glitches.
  always_comb begin
    state_d = state_q;
    timer_d = bit_end ? 16'd0 : timer_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        timer_d = 16'd0;
        idx_d   = 3'd0;
        // A request in the tx_done cycle is accepted here too, which is
        // what lets frames run back to back without an idle bit.
        if (tx_start) begin
          shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          idx_d   = 3'd0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            tx_d  = shift_q[1];
            idx_d = idx_q + 3'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        timer_d = 16'd0;
        idx_d   = 3'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
